obi_multi_cnt: RTL and testbench

Parametrised multi-channel counter/timer peripheral. It is the successor of the single-channel user-domain counter, attached as an OBI subordinate behind the user-domain demux. It provides NumCnt independent counters with per-channel prescaler, compare match, three run modes, W1C status and per-channel level interrupts feeding the external IRQ lines.

---
 rtl/obi_multi_cnt_pkg.sv | 74 +++++++
 rtl/obi_multi_cnt_channel.sv | 138 +++++++++++++
 rtl/obi_multi_cnt.sv | 122 ++++++++++++
 tb/tb_obi_multi_cnt.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_multi_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_multi_cnt_pkg
// Description : Shared definitions for the multi-channel OBI counter/timer:
//               register offsets, run-mode encoding, control register layout,
//               the OBI subordinate request/response types and a byte-enable
//               merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package obi_multi_cnt_pkg;

    // Register offsets inside one channel window (addr[3:0])
    localparam logic [3:0] C_REG_CTRL    = 4'h0;
    localparam logic [3:0] C_REG_VALUE   = 4'h4;
    localparam logic [3:0] C_REG_COMPARE = 4'h8;
    localparam logic [3:0] C_REG_STATUS  = 4'hC;
    localparam logic [7:0] C_CHANNEL_STRIDE = 8'h10;

    localparam int C_AID_WIDTH = 4;

    typedef enum logic [1:0] {
        CNT_FREE     = 2'd0,
        CNT_ONE_SHOT = 2'd1,
        CNT_RELOAD   = 2'd2
    } cnt_mode_e;

    // Mode is kept as raw bits so that the unused encoding 3 reads back as
    // written while behaving like free-run.
    typedef struct packed {
        logic [7:0] presc;
        logic       irq_en;
        logic [1:0] mode;
        logic       en;
    } cnt_ctrl_t;

    typedef struct packed {
        logic [31:0]            addr;
        logic                   we;
        logic [3:0]             be;
        logic [31:0]            wdata;
        logic [C_AID_WIDTH-1:0] aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]            rdata;
        logic [C_AID_WIDTH-1:0] rid;
        logic                   err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

    // Replace the bytes of old_q selected by be with the bytes of wdata
    function automatic logic [31:0] be_merge(input logic [31:0] old_q,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_q;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/obi_multi_cnt_channel.sv
`default_nettype none
// ============================================================================
// Module      : cnt_channel
// Description : One counter/timer channel: prescaler, counter, compare match,
//               run mode handling, W1C status and level interrupt.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_wdata, i_be   - write data and byte enables of the bus
//               i_*_we          - per-register write strobes (already decoded)
//               o_ctrl          - CTRL readback (clear bit reads 0)
//               o_value         - current counter value
//               o_compare       - compare register
//               o_status        - match flag
//               o_irq           - match & irq_en
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_channel
    import obi_multi_cnt_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_wdata,
    input  logic [3:0]           i_be,
    input  logic                 i_ctrl_we,
    input  logic                 i_value_we,
    input  logic                 i_compare_we,
    input  logic                 i_status_we,
    output logic [31:0]          o_ctrl,
    output logic [CNT_WIDTH-1:0] o_value,
    output logic [CNT_WIDTH-1:0] o_compare,
    output logic                 o_status,
    output logic                 o_irq
);

    localparam logic [7:0] C_PRESC_MASK = 8'((1 << PRESC_WIDTH) - 1);

    cnt_ctrl_t              r_ctrl;
    logic [CNT_WIDTH-1:0]   r_value;
    logic [CNT_WIDTH-1:0]   r_compare;
    logic                   r_status;
    logic [PRESC_WIDTH-1:0] r_psc;

    logic [31:0]          w_ctrl_merged;
    logic [31:0]          w_value_merged;
    logic [31:0]          w_compare_merged;
    logic                 w_tick;
    logic                 w_hit;
    logic                 w_clear;
    logic                 w_status_clr;
    logic [CNT_WIDTH-1:0] w_value_inc;
    logic [CNT_WIDTH-1:0] w_value_tick;
    logic                 w_unused;

    assign o_ctrl    = {16'h0, r_ctrl.presc, 4'h0, r_ctrl.irq_en, r_ctrl.mode, r_ctrl.en};
    assign o_value   = r_value;
    assign o_compare = r_compare;
    assign o_status  = r_status;
    assign o_irq     = r_status & r_ctrl.irq_en;

    assign w_ctrl_merged    = be_merge(o_ctrl, i_wdata, i_be);
    assign w_value_merged   = be_merge(32'(r_value), i_wdata, i_be);
    assign w_compare_merged = be_merge(32'(r_compare), i_wdata, i_be);

    // o_ctrl[4] is always 0, so the merged bit is set only by a byte-0 write
    assign w_clear      = i_ctrl_we & w_ctrl_merged[4];
    assign w_status_clr = i_status_we & i_be[0] & i_wdata[0];

    assign w_tick      = r_ctrl.en & (r_psc == r_ctrl.presc[PRESC_WIDTH-1:0]);
    assign w_hit       = w_tick & (r_value == r_compare);
    assign w_value_inc = r_value + CNT_WIDTH'(1);

    always_comb begin
        w_value_tick = w_value_inc;
        if (w_hit) begin
            case (r_ctrl.mode)
                CNT_ONE_SHOT: w_value_tick = r_value;
                CNT_RELOAD:   w_value_tick = '0;
                default:      w_value_tick = w_value_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_value   <= '0;
            r_compare <= '0;
            r_status  <= 1'b0;
            r_psc     <= '0;
        end else begin
            if (w_clear) begin
                r_psc <= '0;
            end else if (r_ctrl.en) begin
                r_psc <= w_tick ? '0 : r_psc + PRESC_WIDTH'(1);
            end

            // clear > software write > tick update
            if (w_clear) begin
                r_value <= '0;
            end else if (i_value_we) begin
                r_value <= w_value_merged[CNT_WIDTH-1:0];
            end else if (w_tick) begin
                r_value <= w_value_tick;
            end

            if (i_compare_we) begin
                r_compare <= w_compare_merged[CNT_WIDTH-1:0];
            end

            // hardware set beats the W1C
            if (w_hit) begin
                r_status <= 1'b1;
            end else if (w_status_clr) begin
                r_status <= 1'b0;
            end

            // a byte-0 CTRL write decides en even when the one-shot fires
            if (i_ctrl_we & i_be[0]) begin
                r_ctrl.en <= i_wdata[0];
            end else if (w_hit && (r_ctrl.mode == CNT_ONE_SHOT)) begin
                r_ctrl.en <= 1'b0;
            end

            if (i_ctrl_we) begin
                r_ctrl.mode   <= w_ctrl_merged[2:1];
                r_ctrl.irq_en <= w_ctrl_merged[3];
                r_ctrl.presc  <= w_ctrl_merged[15:8] & C_PRESC_MASK;
            end
        end
    end

    assign w_unused = ^{w_ctrl_merged[31:16], w_ctrl_merged[7:5], w_ctrl_merged[0],
                        w_value_merged, w_compare_merged};

endmodule
`default_nettype wire

// File: rtl/obi_multi_cnt.sv
`default_nettype none
// ============================================================================
// Module      : obi_multi_cnt
// Description : Multi-channel counter/timer OBI subordinate. Decodes the bus
//               access, fans write strobes out to NUM_CNT channels and
//               registers a single-cycle response.
// Ports       : clk_i      - clock
//               rst_i      - synchronous active-high reset
//               obi_req_i  - OBI request
//               obi_rsp_o  - OBI response (gnt combinational, r registered)
//               irq_o      - per-channel level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module obi_multi_cnt
    import obi_multi_cnt_pkg::*;
#(
    parameter int  NUM_CNT     = 4,
    parameter int  CNT_WIDTH   = 32,
    parameter int  PRESC_WIDTH = 8,
    parameter type obi_req_t   = sbr_obi_req_t,
    parameter type obi_rsp_t   = sbr_obi_rsp_t
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  obi_req_t           obi_req_i,
    output obi_rsp_t           obi_rsp_o,
    output logic [NUM_CNT-1:0] irq_o
);

    logic [3:0]           w_ch;
    logic [3:0]           w_reg_off;
    logic                 w_ch_valid;
    logic                 w_wr;
    logic [31:0]          w_rdata_sel;
    logic                 w_unused;

    logic [31:0]          w_rd_ctrl    [NUM_CNT];
    logic [CNT_WIDTH-1:0] w_rd_value   [NUM_CNT];
    logic [CNT_WIDTH-1:0] w_rd_compare [NUM_CNT];
    logic [NUM_CNT-1:0]   w_rd_status;

    logic                   r_rvalid;
    logic [31:0]            r_rdata;
    logic [C_AID_WIDTH-1:0] r_rid;
    logic                   r_err;

    assign w_ch       = obi_req_i.a.addr[7:4];
    assign w_reg_off  = {obi_req_i.a.addr[3:2], 2'b00};
    assign w_ch_valid = ({1'b0, w_ch} < 5'(NUM_CNT));
    assign w_wr       = obi_req_i.req & obi_req_i.a.we & w_ch_valid;

    generate
        for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
            logic w_sel;
            assign w_sel = w_wr & (w_ch == 4'(i));

            cnt_channel #(
                .CNT_WIDTH   (CNT_WIDTH),
                .PRESC_WIDTH (PRESC_WIDTH)
            ) u_channel (
                .clk          (clk_i),
                .rst          (rst_i),
                .i_wdata      (obi_req_i.a.wdata),
                .i_be         (obi_req_i.a.be),
                .i_ctrl_we    (w_sel & (w_reg_off == C_REG_CTRL)),
                .i_value_we   (w_sel & (w_reg_off == C_REG_VALUE)),
                .i_compare_we (w_sel & (w_reg_off == C_REG_COMPARE)),
                .i_status_we  (w_sel & (w_reg_off == C_REG_STATUS)),
                .o_ctrl       (w_rd_ctrl[i]),
                .o_value      (w_rd_value[i]),
                .o_compare    (w_rd_compare[i]),
                .o_status     (w_rd_status[i]),
                .o_irq        (irq_o[i])
            );
        end
    endgenerate

    // Read mux; invalid channels fall through to zero
    always_comb begin
        w_rdata_sel = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (w_ch == 4'(i)) begin
                case (w_reg_off)
                    C_REG_CTRL:    w_rdata_sel = w_rd_ctrl[i];
                    C_REG_VALUE:   w_rdata_sel = 32'(w_rd_value[i]);
                    C_REG_COMPARE: w_rdata_sel = 32'(w_rd_compare[i]);
                    default:       w_rdata_sel = {31'h0, w_rd_status[i]};
                endcase
            end
        end
    end

    // Response captures the pre-write state of the granted access
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= obi_req_i.req;
            if (obi_req_i.req) begin
                r_rid   <= obi_req_i.a.aid;
                r_err   <= ~w_ch_valid;
                r_rdata <= (w_ch_valid & ~obi_req_i.a.we) ? w_rdata_sel : '0;
            end
        end
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = r_rvalid;
        obi_rsp_o.r.rdata = r_rdata;
        obi_rsp_o.r.rid   = r_rid;
        obi_rsp_o.r.err   = r_err;
    end

    assign w_unused = ^{obi_req_i.a.addr[31:8], obi_req_i.a.addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_obi_multi_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_multi_cnt
// Description : Self-checking bench for obi_multi_cnt: directed scenarios
//               followed by random bus traffic, compared every cycle against
//               a behavioural model of the register file and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_multi_cnt;
    import obi_multi_cnt_pkg::*;

    localparam int NUM_CNT     = 4;
    localparam int CNT_WIDTH   = 16;
    localparam int PRESC_WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    sbr_obi_req_t       req;
    sbr_obi_rsp_t       rsp;
    logic [NUM_CNT-1:0] irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obi_multi_cnt #(
        .NUM_CNT     (NUM_CNT),
        .CNT_WIDTH   (CNT_WIDTH),
        .PRESC_WIDTH (PRESC_WIDTH)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .irq_o     (irq)
    );

    // ------------------------------------------------------------ model state
    bit          m_en     [NUM_CNT];
    logic [1:0]  m_mode   [NUM_CNT];
    bit          m_irq_en [NUM_CNT];
    logic [7:0]  m_presc  [NUM_CNT];
    logic [31:0] m_value  [NUM_CNT];
    logic [31:0] m_cmp    [NUM_CNT];
    bit          m_status [NUM_CNT];
    int          m_psc    [NUM_CNT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] res;
        res = 0;
        for (int k = 0; k < 4; k++)
            res = res | (((b[k] ? d : old_v) >> (8 * k)) & 32'hFF) << (8 * k);
        return res;
    endfunction

    function automatic logic [31:0] m_read(input int c, input int rg);
        case (rg)
            0:       return 32'(m_en[c]) | (32'(m_mode[c]) << 1) | (32'(m_irq_en[c]) << 3)
                            | (32'(m_presc[c]) << 8);
            1:       return m_value[c];
            2:       return m_cmp[c];
            default: return 32'(m_status[c]);
        endcase
    endfunction

    function automatic logic [NUM_CNT-1:0] m_irq();
        logic [NUM_CNT-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CNT; c++) v[c] = m_status[c] & m_irq_en[c];
        return v;
    endfunction

    // Advance the model by one clock edge given the access granted at that edge
    task automatic model_step(input bit r, input bit v, input bit w, input int ch, input int rg,
                              input logic [3:0] b, input logic [31:0] d);
        logic [31:0] vmask;
        vmask = (32'h1 << CNT_WIDTH) - 1;
        for (int c = 0; c < NUM_CNT; c++) begin
            bit wr, tick, hit, clr;
            logic [31:0] nv, cw;
            if (r) begin
                m_en[c] = 0; m_mode[c] = 0; m_irq_en[c] = 0; m_presc[c] = 0;
                m_value[c] = 0; m_cmp[c] = 0; m_status[c] = 0; m_psc[c] = 0;
            end else begin
                wr   = v && w && (c == ch);
                tick = m_en[c] && (m_psc[c] == int'(m_presc[c]));
                hit  = tick && (m_value[c] == m_cmp[c]);
                clr  = wr && rg == 0 && b[0] && d[4];
                nv   = m_value[c];
                if (tick) begin
                    if (hit && m_mode[c] == 2)      nv = 0;
                    else if (hit && m_mode[c] == 1) nv = m_value[c];
                    else                            nv = (m_value[c] + 1) & vmask;
                end
                if (wr && rg == 1) nv = merge(m_value[c], d, b) & vmask;
                if (clr) begin
                    nv = 0;
                    m_psc[c] = 0;
                end else if (m_en[c]) begin
                    m_psc[c] = tick ? 0 : (m_psc[c] + 1) % (1 << PRESC_WIDTH);
                end
                if (wr && rg == 3 && b[0] && d[0]) m_status[c] = 0;
                if (hit) m_status[c] = 1;
                if (hit && m_mode[c] == 1) m_en[c] = 0;
                if (wr && rg == 2) m_cmp[c] = merge(m_cmp[c], d, b) & vmask;
                if (wr && rg == 0) begin
                    cw = merge(m_read(c, 0), d, b);
                    m_en[c]     = cw[0];
                    m_mode[c]   = cw[2:1];
                    m_irq_en[c] = cw[3];
                    m_presc[c]  = cw[15:8] & 8'((1 << PRESC_WIDTH) - 1);
                end
                m_value[c] = nv;
            end
        end
    endtask

    // One clock cycle with an optional access; checks grant, response and irq
    task automatic bus_cycle(input bit r, input bit v, input bit w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d, input logic [3:0] id);
        int ch, rg;
        logic [31:0] exp_d;
        bit exp_e;
        rst         = r;
        req.req     = v;
        req.a.addr  = a;
        req.a.we    = w;
        req.a.be    = b;
        req.a.wdata = d;
        req.a.aid   = id;
        #1;
        check("gnt", 32'(rsp.gnt), 32'(v));
        ch    = int'(a[7:4]);
        rg    = int'(a[3:2]);
        exp_e = (ch >= NUM_CNT);
        exp_d = (!exp_e && !w) ? m_read(ch, rg) : 32'h0;
        @(posedge clk);
        model_step(r, v, w, ch, rg, b, d);
        #1;
        check("rvalid", 32'(rsp.rvalid), 32'(v && !r));
        if (v && !r) begin
            check("rid", 32'(rsp.r.rid), 32'(id));
            check("err", 32'(rsp.r.err), 32'(exp_e));
            check("rdata", rsp.r.rdata, exp_d);
        end
        check("irq", 32'(irq), 32'(m_irq()));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bus_cycle(1'b0, 1'b1, 1'b1, a, b, d, 4'h1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_cycle(1'b0, 1'b1, 1'b0, a, 4'hF, 32'h0, 4'h2);
        d = rsp.r.rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    endtask

    logic [31:0] rdv;
    logic [31:0] exp_seq [9];

    initial begin
        req = '0;
        rst = 1'b1;
        bus_cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        bus_cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);

        // Reset state and reset in the middle of a write
        rd(32'h00, rdv);  check("rst_ctrl", rdv, 32'h0);
        wr(32'h04, 32'h1234, 4'hF);
        bus_cycle(1'b1, 1'b1, 1'b1, 32'h08, 4'hF, 32'h77, 4'h3);
        bus_cycle(1'b1, 1'b1, 1'b1, 32'h08, 4'hF, 32'h77, 4'h3);
        rd(32'h04, rdv);  check("rst_value", rdv, 32'h0);
        rd(32'h08, rdv);  check("rst_cmp", rdv, 32'h0);

        // Free-run wrap on channel 0
        wr(32'h04, 32'hFFFE, 4'hF);
        wr(32'h08, 32'h0010, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        rd(32'h04, rdv);  check("wrap0", rdv, 32'hFFFE);
        rd(32'h04, rdv);  check("wrap1", rdv, 32'hFFFF);
        rd(32'h04, rdv);  check("wrap2", rdv, 32'h0000);
        rd(32'h0C, rdv);  check("wrap_nomatch", rdv, 32'h0);
        idle(20);
        rd(32'h0C, rdv);  check("wrap_match", rdv, 32'h1);
        wr(32'h00, 32'h0, 4'hF);

        // Auto-reload with prescaler 1 and interrupt on channel 1
        exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        wr(32'h18, 32'h3, 4'hF);
        wr(32'h10, 32'h10D, 4'hF);
        for (int k = 0; k < 9; k++) begin
            rd(32'h14, rdv);
            check("reload_seq", rdv, exp_seq[k]);
        end
        check("reload_irq", 32'(irq[1]), 32'h1);
        wr(32'h1C, 32'h1, 4'h1);
        check("reload_w1c_irq", 32'(irq[1]), 32'h0);
        wr(32'h10, 32'h0, 4'hF);

        // One-shot on channel 2 with a W1C colliding with the match
        wr(32'h28, 32'h5, 4'hF);
        wr(32'h20, 32'h3, 4'hF);
        idle(5);
        wr(32'h2C, 32'h1, 4'h1);
        rd(32'h2C, rdv);  check("oneshot_status", rdv, 32'h1);
        rd(32'h20, rdv);  check("oneshot_ctrl", rdv, 32'h2);
        rd(32'h24, rdv);  check("oneshot_value", rdv, 32'h5);

        // Out-of-range channel
        bus_cycle(1'b0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 4'h5);
        check("oor_err", 32'(rsp.r.err), 32'h1);
        check("oor_rid", 32'(rsp.r.rid), 32'h5);
        check("oor_rdata", rsp.r.rdata, 32'h0);
        wr(32'h44, 32'hFFFF_FFFF, 4'hF);

        // Byte enables on channel 3
        wr(32'h34, 32'hAABB_CCDD, 4'b0010);
        rd(32'h34, rdv);  check("be_value", rdv, 32'h0000_CC00);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            bit          r, v, w;
            int          ch, rg;
            logic [31:0] d;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 3) != 0);
            w  = $urandom_range(0, 1) == 1;
            ch = $urandom_range(0, NUM_CNT);
            rg = $urandom_range(0, 3);
            case (rg)
                0: begin
                    d = $urandom & 32'h0000_3F2F;
                    if ($urandom_range(0, 7) == 0) d = d | 32'h10;
                end
                1, 2:    d = $urandom_range(0, 24);
                default: d = $urandom;
            endcase
            bus_cycle(r, v, w, 32'(ch) * 32'(C_CHANNEL_STRIDE) + 32'(rg * 4) + ($urandom & 32'hFFFF_FF00),
                      4'($urandom), d, 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
